// File: rtl/maze_pixel_if.sv
// Pixel-side bundle of the maze renderer.
// The master drives coordinates, RAM data and robot state.
// The slave, which is the renderer, returns the RAM address and the pixel colour.
interface maze_pixel_if #(
    parameter int ADDR_W = 5
) ();
    logic [9:0]        x_coord;
    logic [9:0]        y_coord;
    logic              pix_valid;
    logic              vsync_pulse;
    logic [ADDR_W-1:0] cell_addr;
    logic [2:0]        cell_value;
    logic [3:0]        robot_x;
    logic [3:0]        robot_y;
    logic              blink_en;
    logic [7:0]        color;
    logic              color_valid;

    modport master (
        output x_coord, y_coord, pix_valid, vsync_pulse, cell_value,
               robot_x, robot_y, blink_en,
        input  cell_addr, color, color_valid
    );

    modport slave (
        input  x_coord, y_coord, pix_valid, vsync_pulse, cell_value,
               robot_x, robot_y, blink_en,
        output cell_addr, color, color_valid
    );
endinterface

// File: rtl/maze_pixel_renderer.sv
// Three-stage per-pixel colour generator for the maze display.
// Stage 1 maps a coordinate to a grid cell, drives the RAM address and captures the cell flags.
// Stage 2 holds the flags while the synchronous grid RAM returns the cell state.
// Stage 3 resolves the RGB332 colour, including the blinking robot overlay.
module maze_pixel_renderer #(
    parameter int CELL_LOG2  = 5,
    parameter int GRID_W     = 4,
    parameter int GRID_H     = 5,
    parameter int ADDR_W     = 5,
    parameter int BLINK_LOG2 = 5
) (
    input  logic         clock_25,
    input  logic         reset_n,
    maze_pixel_if.slave  bus
);
    localparam int unsigned CELL_PIX = 32'd1 << CELL_LOG2;
    // The centre band is a quarter of the cell wide, for example 12..19 in a 32-pixel cell.
    localparam int unsigned BAND_LO  = CELL_PIX / 32'd2 - CELL_PIX / 32'd8;
    localparam int unsigned BAND_HI  = CELL_PIX / 32'd2 + CELL_PIX / 32'd8 - 32'd1;

    localparam logic [7:0] COL_BLACK     = 8'b000_000_00;
    localparam logic [7:0] COL_WHITE     = 8'b111_111_11;
    localparam logic [7:0] COL_UNVISITED = 8'b110_000_01;
    localparam logic [7:0] COL_VISITED   = 8'b001_011_11;
    localparam logic [7:0] COL_GREEN     = 8'b000_111_00;
    localparam logic [7:0] COL_RED       = 8'b111_000_00;
    localparam logic [7:0] COL_BLUE      = 8'b000_000_11;
    localparam logic [7:0] COL_YELLOW    = 8'b101_101_00;

    // True when an in-cell offset falls inside the centre band.
    function automatic logic in_band(input logic [CELL_LOG2-1:0] offset);
        return (32'(offset) >= BAND_LO) && (32'(offset) <= BAND_HI);
    endfunction

    // Colour for a grid cell, before the robot overlay is applied.
    // A path cell draws a green stub that depends on the cell's parity position:
    //   even column, even row -> cross (either band)
    //   even column, odd row  -> vertical stub (x band)
    //   odd column            -> horizontal stub (y band)
    function automatic logic [7:0] cell_color(
        input logic [2:0] value,
        input logic       col0,
        input logic       row0,
        input logic       bx,
        input logic       by
    );
        logic       green;
        logic [7:0] result;
        case ({col0, row0})
            2'b00:   green = bx | by;
            2'b01:   green = bx;
            2'b10:   green = by;
            2'b11:   green = by;
            default: green = 1'b0;
        endcase
        case (value)
            3'd0:    result = COL_UNVISITED;
            3'd1:    result = COL_VISITED;
            3'd2:    result = green ? COL_GREEN : COL_VISITED;
            3'd3:    result = COL_RED;
            3'd4:    result = COL_GREEN;
            3'd5:    result = COL_BLUE;
            3'd6:    result = COL_YELLOW;
            3'd7:    result = COL_YELLOW;
            default: result = COL_BLACK;
        endcase
        return result;
    endfunction

    // Stage 0: combinational cell decode of the incoming coordinate.
    logic [9:0]           col_s;
    logic [9:0]           row_s;
    logic [CELL_LOG2-1:0] ox_s;
    logic [CELL_LOG2-1:0] oy_s;
    logic                 in_grid_s;
    logic                 robot_hit_s;
    logic [ADDR_W-1:0]    addr_s;

    // Stage 1 registers.
    logic [ADDR_W-1:0] cell_addr_r;
    logic              valid1_r;
    logic              in_grid1_r;
    logic              robot1_r;
    logic              bx1_r;
    logic              by1_r;
    logic              col0_1_r;
    logic              row0_1_r;

    // Stage 2 registers. They are aligned with the RAM read data.
    logic valid2_r;
    logic in_grid2_r;
    logic robot2_r;
    logic bx2_r;
    logic by2_r;
    logic col0_2_r;
    logic row0_2_r;

    // Stage 3 and frame state.
    logic [BLINK_LOG2-1:0] frame_r;
    logic                  phase_s;
    logic [7:0]            pixel_color_s;
    logic [7:0]            color_r;
    logic                  color_valid_r;

    // Decode column/row, offsets, grid membership, robot hit and linear RAM address.
    always_comb begin
        col_s       = bus.x_coord >> CELL_LOG2;
        row_s       = bus.y_coord >> CELL_LOG2;
        ox_s        = bus.x_coord[CELL_LOG2-1:0];
        oy_s        = bus.y_coord[CELL_LOG2-1:0];
        in_grid_s   = (32'(col_s) < 32'(GRID_W)) && (32'(row_s) < 32'(GRID_H));
        robot_hit_s = (col_s == {6'd0, bus.robot_x}) && (row_s == {6'd0, bus.robot_y});
        if (in_grid_s) begin
            addr_s = ADDR_W'(32'(row_s) * 32'(GRID_W) + 32'(col_s));
        end else begin
            addr_s = {ADDR_W{1'b0}};
        end
    end

    // Stage 1: register the RAM address and the per-pixel flags.
    // The robot position is sampled here, so a mid-frame move affects only later pixels.
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            cell_addr_r <= {ADDR_W{1'b0}};
            valid1_r    <= 1'b0;
            in_grid1_r  <= 1'b0;
            robot1_r    <= 1'b0;
            bx1_r       <= 1'b0;
            by1_r       <= 1'b0;
            col0_1_r    <= 1'b0;
            row0_1_r    <= 1'b0;
        end else begin
            cell_addr_r <= addr_s;
            valid1_r    <= bus.pix_valid;
            in_grid1_r  <= in_grid_s;
            robot1_r    <= robot_hit_s;
            bx1_r       <= in_band(ox_s);
            by1_r       <= in_band(oy_s);
            col0_1_r    <= col_s[0];
            row0_1_r    <= row_s[0];
        end
    end

    // Stage 2: forward the flags so they line up with the RAM data returned one cycle later.
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            valid2_r   <= 1'b0;
            in_grid2_r <= 1'b0;
            robot2_r   <= 1'b0;
            bx2_r      <= 1'b0;
            by2_r      <= 1'b0;
            col0_2_r   <= 1'b0;
            row0_2_r   <= 1'b0;
        end else begin
            valid2_r   <= valid1_r;
            in_grid2_r <= in_grid1_r;
            robot2_r   <= robot1_r;
            bx2_r      <= bx1_r;
            by2_r      <= by1_r;
            col0_2_r   <= col0_1_r;
            row0_2_r   <= row0_1_r;
        end
    end

    // Frame counter: advance on each frame-start strobe and wrap naturally at full scale.
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            frame_r <= {BLINK_LOG2{1'b0}};
        end else if (bus.vsync_pulse) begin
            frame_r <= frame_r + 1'b1;
        end else begin
            frame_r <= frame_r;
        end
    end

    // Colour priority: blank, then the robot overlay in the centre of its cell, then the cell state.
    // The blink phase is read before any same-edge counter increment.
    always_comb begin
        phase_s       = frame_r[BLINK_LOG2-1];
        pixel_color_s = COL_BLACK;
        if (!valid2_r || !in_grid2_r) begin
            pixel_color_s = COL_BLACK;
        end else if (robot2_r && bx2_r && by2_r && !(bus.blink_en && phase_s)) begin
            pixel_color_s = COL_WHITE;
        end else begin
            pixel_color_s = cell_color(bus.cell_value, col0_2_r, row0_2_r, bx2_r, by2_r);
        end
    end

    // Stage 3: register the output colour and its validity.
    // Validity tracks the pixel strobe even outside the grid.
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            color_r       <= 8'd0;
            color_valid_r <= 1'b0;
        end else begin
            color_r       <= pixel_color_s;
            color_valid_r <= valid2_r;
        end
    end

    assign bus.cell_addr   = cell_addr_r;
    assign bus.color       = color_r;
    assign bus.color_valid = color_valid_r;
endmodule

// File: tb/tb_maze_pixel_renderer.sv
// Self-checking bench for maze_pixel_renderer.
// A grid RAM model answers CELL_ADDR one cycle later.
// Expected colours are queued as each pixel is driven and compared three cycles later.
module tb_maze_pixel_renderer;
    localparam logic [7:0] BLK = 8'b000_000_00;
    localparam logic [7:0] WHT = 8'b111_111_11;
    localparam logic [7:0] UNV = 8'b110_000_01;
    localparam logic [7:0] VIS = 8'b001_011_11;
    localparam logic [7:0] GRN = 8'b000_111_00;
    localparam logic [7:0] RED = 8'b111_000_00;
    localparam logic [7:0] BLU = 8'b000_000_11;
    localparam logic [7:0] YEL = 8'b101_101_00;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       pv;
        logic [7:0] ec;
        logic       ev;
        logic [4:0] ea;
    } vec_t;

    typedef struct {
        logic [7:0] c;
        logic       v;
        string      nm;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [2:0] ram [32];
    logic [2:0] ram_q;
    int n_cmp;
    int n_bad;
    exp_t q[$];
    vec_t tbl[$];

    maze_pixel_if #(.ADDR_W(5)) bus ();

    maze_pixel_renderer #(
        .CELL_LOG2 (5),
        .GRID_W    (4),
        .GRID_H    (5),
        .ADDR_W    (5),
        .BLINK_LOG2(2)
    ) dut (
        .clock_25(clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Synchronous-read grid RAM model.
    always_ff @(posedge clk) ram_q <= ram[bus.cell_addr];
    assign bus.cell_value = ram_q;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one pixel for one cycle.
    // The address is checked one edge later; the queued colour from three pixels ago is checked now.
    task automatic step(input logic [9:0] x, input logic [9:0] y, input logic pv, input logic vs,
                        input logic [7:0] ec, input logic ev, input logic [4:0] ea, input string nm);
        exp_t e;
        bus.x_coord     = x;
        bus.y_coord     = y;
        bus.pix_valid   = pv;
        bus.vsync_pulse = vs;
        q.push_back('{ec, ev, nm});
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_addr"}, 8'(bus.cell_addr), 8'(ea));
        if (q.size() == 3) begin
            e = q.pop_front();
            chk({e.nm, "_color"}, bus.color, e.c);
            chk({e.nm, "_valid"}, 8'(bus.color_valid), 8'(e.v));
        end
    endtask

    task automatic idle(input logic vs);
        step(10'd0, 10'd0, 1'b0, vs, BLK, 1'b0, 5'd0, "idle");
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) idle(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 32; i++) ram[i] = 3'd0;

        // Stimulus table for the main colour function; RAM is loaded before it is applied.
        tbl.push_back('{10'd12,  10'd3,   1'b1, GRN, 1'b1, 5'd0});
        tbl.push_back('{10'd11,  10'd11,  1'b1, VIS, 1'b1, 5'd0});
        tbl.push_back('{10'd3,   10'd16,  1'b1, GRN, 1'b1, 5'd0});
        tbl.push_back('{10'd19,  10'd0,   1'b1, GRN, 1'b1, 5'd0});
        tbl.push_back('{10'd20,  10'd0,   1'b1, VIS, 1'b1, 5'd0});
        tbl.push_back('{10'd37,  10'd15,  1'b1, GRN, 1'b1, 5'd1});
        tbl.push_back('{10'd44,  10'd5,   1'b1, VIS, 1'b1, 5'd1});
        tbl.push_back('{10'd15,  10'd40,  1'b1, GRN, 1'b1, 5'd4});
        tbl.push_back('{10'd8,   10'd44,  1'b1, VIS, 1'b1, 5'd4});
        tbl.push_back('{10'd128, 10'd0,   1'b1, BLK, 1'b1, 5'd0});
        tbl.push_back('{10'd0,   10'd160, 1'b1, BLK, 1'b1, 5'd0});
        tbl.push_back('{10'd40,  10'd40,  1'b0, BLK, 1'b0, 5'd5});
        tbl.push_back('{10'd64,  10'd0,   1'b1, RED, 1'b1, 5'd2});
        tbl.push_back('{10'd96,  10'd0,   1'b1, GRN, 1'b1, 5'd3});
        tbl.push_back('{10'd32,  10'd32,  1'b1, BLU, 1'b1, 5'd5});
        tbl.push_back('{10'd64,  10'd32,  1'b1, YEL, 1'b1, 5'd6});
        tbl.push_back('{10'd96,  10'd32,  1'b1, YEL, 1'b1, 5'd7});
        tbl.push_back('{10'd0,   10'd64,  1'b1, VIS, 1'b1, 5'd8});
        tbl.push_back('{10'd127, 10'd159, 1'b1, UNV, 1'b1, 5'd19});

        rst_n           = 1'b0;
        bus.x_coord     = 10'd0;
        bus.y_coord     = 10'd0;
        bus.pix_valid   = 1'b0;
        bus.vsync_pulse = 1'b0;
        bus.robot_x     = 4'd15;
        bus.robot_y     = 4'd15;
        bus.blink_en    = 1'b0;
        #5;
        chk("reset_color", bus.color, BLK);
        chk("reset_valid", 8'(bus.color_valid), 8'd0);
        chk("reset_addr", 8'(bus.cell_addr), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-stream: outputs clear at once, then the pipeline refills with latency 3.
        for (int i = 0; i < 4; i++) step(10'd0, 10'd0, 1'b1, 1'b0, UNV, 1'b1, 5'd0, "pre_rst");
        rst_n = 1'b0;
        #1;
        chk("midrst_color", bus.color, BLK);
        chk("midrst_valid", 8'(bus.color_valid), 8'd0);
        chk("midrst_addr", 8'(bus.cell_addr), 8'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(10'd0, 10'd0, 1'b1, 1'b0, UNV, 1'b1, 5'd0, "post_rst_p0");
        chk("post_rst_gap1", 8'(bus.color_valid), 8'd0);
        idle(1'b0);
        chk("post_rst_gap2", 8'(bus.color_valid), 8'd0);
        idle(1'b0);
        drain();

        // A full row of cell 0 holding the unvisited state.
        for (int x = 0; x < 32; x++)
            step(10'(x), 10'd0, 1'b1, 1'b0, UNV, 1'b1, 5'd0, $sformatf("row_x%0d", x));
        drain();

        // Table-driven back-to-back pixels over path, treasure and out-of-grid cells.
        ram[0] = 3'd2; ram[1] = 3'd2; ram[4] = 3'd2;
        ram[2] = 3'd3; ram[3] = 3'd4; ram[5] = 3'd5;
        ram[6] = 3'd6; ram[7] = 3'd7; ram[8] = 3'd1; ram[9] = 3'd0;
        foreach (tbl[i])
            step(tbl[i].x, tbl[i].y, tbl[i].pv, 1'b0, tbl[i].ec, tbl[i].ev, tbl[i].ea,
                 $sformatf("tbl%0d", i));
        drain();

        // Blinking robot at (1,2); counter starts at 0 and one strobe follows each frame.
        bus.robot_x  = 4'd1;
        bus.robot_y  = 4'd2;
        bus.blink_en = 1'b1;
        for (int f = 0; f < 5; f++) begin
            step(10'd48, 10'd80, 1'b1, 1'b0, ((f % 4) < 2) ? WHT : UNV, 1'b1, 5'd9,
                 $sformatf("blink_f%0d", f));
            drain();
            idle(1'b1);
        end

        // Counter is 1 here; the strobe lands on pixel A's output edge, so A sees phase 0 and B sees phase 1.
        step(10'd48, 10'd80, 1'b1, 1'b0, WHT, 1'b1, 5'd9, "vs_edge_a");
        step(10'd48, 10'd80, 1'b1, 1'b0, UNV, 1'b1, 5'd9, "vs_edge_b");
        idle(1'b1);
        drain();

        // Counter is 2 (phase 1); with blinking off the robot stays visible.
        // An off-centre pixel of the robot cell shows the cell colour.
        bus.blink_en = 1'b0;
        step(10'd48, 10'd80, 1'b1, 1'b0, WHT, 1'b1, 5'd9, "noblink");
        step(10'd33, 10'd65, 1'b1, 1'b0, UNV, 1'b1, 5'd9, "robot_edge");
        bus.robot_x = 4'd2;
        step(10'd48, 10'd80, 1'b1, 1'b0, UNV, 1'b1, 5'd9, "robot_moved_old");
        step(10'd80, 10'd80, 1'b1, 1'b0, WHT, 1'b1, 5'd10, "robot_moved_new");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
